// File: rtl/core_pkg.sv
// core_pkg: shared fetch-entry type, default sizes and lane-count helper for the issue queue
package core_pkg;
  localparam int ENTRY_W_DEF = 64;
  localparam int DEPTH_DEF = 8;
  localparam int PTR_W = $clog2(DEPTH_DEF);
  localparam int CNT_W = $clog2(DEPTH_DEF + 1);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  function automatic int unsigned popcount_contig(input logic [31:0] v);
    int unsigned n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/issue_queue.sv
// issue_queue: multi-lane in-order instruction queue between fetch and decode
module issue_queue
  import core_pkg::*;
#(
  parameter int ENTRY_W = ENTRY_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PUSH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int AF_THRESH = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [PUSH_W-1:0]             in_valid,
  input  logic [PUSH_W*ENTRY_W-1:0]     in_data,
  output logic                          in_ready,
  input  logic                          stall,
  input  logic [$clog2(ISSUE_W+1)-1:0]  deq_cnt,
  output logic [ISSUE_W-1:0]            out_valid,
  output logic [ISSUE_W*ENTRY_W-1:0]    out_data,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] push_n, push_acc, pop_req, pop_n, avail;
  // in_ready looks only at registered count so fetch never sees a loop through valid/deq
  always_comb begin
    push_n = CW'(popcount_contig(32'(in_valid)));
    in_ready = (CW'(DEPTH) - count) >= CW'(PUSH_W);
    push_acc = in_ready ? push_n : '0;
    pop_req = stall ? '0 : CW'(deq_cnt);
    pop_n = pop_req > count ? count : pop_req;
    avail = count < CW'(ISSUE_W) ? count : CW'(ISSUE_W);
    empty = count == '0;
    full = count == CW'(DEPTH);
    almost_full = count >= CW'(AF_THRESH);
    for (int i = 0; i < ISSUE_W; i++) begin
      out_valid[i] = count > CW'(i);
      out_data[i*ENTRY_W +: ENTRY_W] = mem[head + PW'(i)];
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_W; i++)
      if (in_ready && in_valid[i]) mem[tail + PW'(i)] <= in_data[i*ENTRY_W +: ENTRY_W];
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PW'(pop_n);
      tail <= tail + PW'(push_acc);
      count <= count + push_acc - pop_n;
    end
    if (!rst) begin
      assert ((in_valid & (in_valid + 1'b1)) == '0);
      assert (stall || CW'(deq_cnt) <= avail);
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed plus randomized checks of issue_queue against a queue-based model
module tb_issue_queue;
  import core_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, flush, stall, in_ready, empty, full, almost_full;
  logic [1:0] in_valid, deq_cnt, out_valid;
  logic [127:0] in_data, out_data;
  logic [3:0] count;
  int total = 0, bad = 0, pc = 0;
  logic [63:0] q[$];
  issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .stall(stall), .deq_cnt(deq_cnt), .out_valid(out_valid),
    .out_data(out_data), .count(count), .empty(empty), .full(full), .almost_full(almost_full)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic check_state();
    int n = q.size();
    chk("count", 64'(count), 64'(n));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("full", 64'(full), 64'(n == 8));
    chk("almost_full", 64'(almost_full), 64'(n >= 6));
    chk("in_ready", 64'(in_ready), 64'(8 - n >= 2));
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("out_valid%0d", i), 64'(out_valid[i]), 64'(n > i));
      if (n > i) chk($sformatf("out_data%0d", i), out_data[i*64 +: 64], q[i]);
    end
  endtask
  task automatic step(input logic r, input logic f, input logic [1:0] v, input logic s, input int d);
    fetch_entry_t lane [2];
    int n = q.size();
    bit rdy = (8 - n) >= 2;
    int pn = int'(v[0]) + int'(v[1]);
    int pp = s ? 0 : (d < n ? d : n);
    check_state();
    for (int i = 0; i < 2; i++) begin
      lane[i].pc = 32'(pc + 4 * i);
      lane[i].instr = $urandom;
      in_data[i*64 +: 64] = lane[i];
    end
    rst = r; flush = f; in_valid = v; stall = s; deq_cnt = 2'(d);
    @(posedge clk);
    if (r || f) q.delete();
    else begin
      repeat (pp) void'(q.pop_front());
      if (rdy) begin
        for (int i = 0; i < pn; i++) q.push_back(lane[i]);
        pc += 4 * pn;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = '0; deq_cnt = '0; in_data = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    repeat (4) step(0, 0, 2'b11, 0, 0);
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_lane0_pc", 64'(out_data[63:32]), 64'h00);
    chk("fill_lane1_pc", 64'(out_data[127:96]), 64'h04);
    step(0, 0, 2'b11, 0, 2);
    chk("full_reject_count", 64'(count), 64'd6);
    chk("full_reject_head", 64'(out_data[63:32]), 64'h08);
    step(0, 0, 2'b00, 0, 2);
    step(0, 0, 2'b00, 0, 2);
    repeat (3) step(0, 0, 2'b11, 0, 0);
    chk("wrap_count", 64'(count), 64'd8);
    chk("wrap_head", 64'(out_data[63:32]), 64'h18);
    step(0, 0, 2'b00, 0, 2);
    chk("wrap_next", 64'(out_data[63:32]), 64'h20);
    step(0, 0, 2'b00, 0, 2);
    step(0, 0, 2'b00, 0, 1);
    chk("partial_pre", 64'(count), 64'd3);
    step(0, 0, 2'b00, 0, 1);
    chk("partial_count", 64'(count), 64'd2);
    chk("partial_valid", 64'(out_valid), 64'd3);
    step(0, 0, 2'b00, 1, 2);
    chk("stall_count", 64'(count), 64'd2);
    step(0, 0, 2'b11, 0, 0);
    step(0, 0, 2'b01, 0, 0);
    chk("pre_flush", 64'(count), 64'd5);
    step(0, 1, 2'b11, 0, 2);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    repeat (3) step(0, 0, 2'b11, 0, 0);
    step(0, 0, 2'b01, 0, 0);
    chk("pre_rst", 64'(count), 64'd7);
    step(1, 0, 2'b11, 0, 0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    step(0, 0, 2'b01, 0, 0);
    chk("post_rst_lane0", 64'(out_data[63:32]), 64'(pc - 4));
    for (int k = 0; k < 400; k++) begin
      int n = q.size();
      int mx = n < 2 ? n : 2;
      logic [1:0] v;
      case ($urandom_range(0, 2))
        0: v = 2'b00;
        1: v = 2'b01;
        default: v = 2'b11;
      endcase
      step($urandom_range(0, 60) == 0, $urandom_range(0, 30) == 0, v,
           $urandom_range(0, 4) == 0, $urandom_range(0, mx));
    end
    check_state();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
